// File: rtl/pc_ctrl_pkg.sv
// Shared encodings for the next-PC mux controller: request kinds,
// mux select values, controller states and the kind-to-select mapping.
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        KIND_SEQ    = 2'd0,
        KIND_BRANCH = 2'd1,
        KIND_JUMP   = 2'd2,
        KIND_EXC    = 2'd3
    } kind_e;

    localparam logic [1:0] SEL_PC4    = 2'd0;
    localparam logic [1:0] SEL_BRANCH = 2'd1;
    localparam logic [1:0] SEL_JUMP   = 2'd2;
    localparam logic [1:0] SEL_EXC    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_COMMIT = 2'd2,
        ST_TRAP   = 2'd3
    } state_e;

    function automatic logic [1:0] sel_map(input kind_e kind, input logic taken);
        logic [1:0] sel;
        sel = SEL_PC4;
        unique case (kind)
            KIND_SEQ:    sel = SEL_PC4;
            KIND_BRANCH: sel = taken ? SEL_BRANCH : SEL_PC4;
            KIND_JUMP:   sel = SEL_JUMP;
            KIND_EXC:    sel = SEL_EXC;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/pc_update_ctrl.sv
// Next-PC mux controller holding the architectural PC; redirects misaligned
// targets to the exception vector. Define PC_RETIRE_CNT_EN for retire/trap counters.
module pc_update_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int unsigned       PC_W         = 32,
    parameter logic [PC_W-1:0]   RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_kind,
    input  logic            branch_taken,
    input  logic            stall,
    input  logic [PC_W-1:0] pc_next,
    output logic [1:0]      selector,
    output logic [PC_W-1:0] pc,
    output logic            pc_write,
    output logic            done,
    output logic            trap
`ifdef PC_RETIRE_CNT_EN
    ,
    output logic [31:0]     retire_cnt,
    output logic [15:0]     trap_cnt
`endif
);

    state_e          r_state;
    state_e          w_next;
    kind_e           r_kind;
    logic [1:0]      r_sel;
    logic [1:0]      w_sel_nxt;
    logic [PC_W-1:0] r_pc;
    logic            w_commit;
    logic            w_trap;
    logic            w_misal;

    // Exception targets are never alignment-checked, so a trap cannot recurse.
    assign w_misal = (pc_next[1:0] != 2'b00) && (r_kind != KIND_EXC);

    always_comb begin
        w_next    = r_state;
        w_sel_nxt = r_sel;
        w_commit  = 1'b0;
        w_trap    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_sel_nxt = SEL_PC4;
                if (req_valid) begin
                    w_next    = ST_SELECT;
                    w_sel_nxt = sel_map(kind_e'(req_kind), branch_taken);
                end
            end
            ST_SELECT: w_next = ST_COMMIT;
            ST_COMMIT: begin
                if (!stall) begin
                    if (w_misal) begin
                        w_sel_nxt = SEL_EXC;
                        w_next    = ST_TRAP;
                    end else begin
                        w_commit  = 1'b1;
                        w_sel_nxt = SEL_PC4;
                        w_next    = ST_IDLE;
                    end
                end
            end
            ST_TRAP: begin
                w_sel_nxt = SEL_EXC;
                if (!stall) begin
                    w_commit  = 1'b1;
                    w_trap    = 1'b1;
                    w_sel_nxt = SEL_PC4;
                    w_next    = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_sel   <= SEL_PC4;
            r_kind  <= KIND_SEQ;
            r_pc    <= RESET_VECTOR;
        end else begin
            r_state <= w_next;
            r_sel   <= w_sel_nxt;
            if (r_state == ST_IDLE && req_valid) begin
                r_kind <= kind_e'(req_kind);
            end
            if (w_commit) begin
                r_pc <= pc_next;
            end
        end
    end

    // Reset gating keeps an aborted operation from committing.
    assign req_ready = (r_state == ST_IDLE) && !reset;
    assign pc_write  = w_commit && !reset;
    assign done      = w_commit && !reset;
    assign trap      = w_trap && !reset;
    assign selector  = r_sel;
    assign pc        = r_pc;

`ifdef PC_RETIRE_CNT_EN
    logic [31:0] r_retire_cnt;
    logic [15:0] r_trap_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_retire_cnt <= '0;
            r_trap_cnt   <= '0;
        end else begin
            if (w_commit) begin
                r_retire_cnt <= r_retire_cnt + 32'd1;
            end
            if (w_trap && r_trap_cnt != 16'hFFFF) begin
                r_trap_cnt <= r_trap_cnt + 16'd1;
            end
        end
    end

    assign retire_cnt = r_retire_cnt;
    assign trap_cnt   = r_trap_cnt;
`endif

endmodule

// File: tb/tb_pc_update_ctrl.sv
// Randomized bench for pc_update_ctrl against a transaction-level PC model;
// the bench plays the role of the 4:1 next-PC mux.
module tb_pc_update_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_kind;
    logic        branch_taken;
    logic        stall;
    logic [31:0] pc_next;
    logic [1:0]  selector;
    logic [31:0] pc;
    logic        pc_write;
    logic        done;
    logic        trap;
`ifdef PC_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
    logic [15:0] trap_cnt;
`endif

    logic [31:0] btgt, jtgt, vec;
    logic [31:0] m_pc;
    logic [31:0] m_ret;
    logic [15:0] m_trp;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_update_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_kind     (req_kind),
        .branch_taken (branch_taken),
        .stall        (stall),
        .pc_next      (pc_next),
        .selector     (selector),
        .pc           (pc),
        .pc_write     (pc_write),
        .done         (done),
        .trap         (trap)
`ifdef PC_RETIRE_CNT_EN
        ,
        .retire_cnt   (retire_cnt),
        .trap_cnt     (trap_cnt)
`endif
    );

    always_comb begin
        case (selector)
            2'd0:    pc_next = pc + 32'd4;
            2'd1:    pc_next = btgt;
            2'd2:    pc_next = jtgt;
            default: pc_next = vec;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_cnt();
`ifdef PC_RETIRE_CNT_EN
        chk("retire_cnt", retire_cnt, m_ret);
        chk("trap_cnt", {16'd0, trap_cnt}, {16'd0, m_trp});
`endif
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            stall = 1'(($urandom_range(1)));
            #1;
            chk("idle_sel", {30'd0, selector}, 32'd0);
            chk("idle_ready", {31'd0, req_ready}, 32'd1);
            chk("idle_wr", {31'd0, pc_write}, 32'd0);
            chk("idle_pc", pc, m_pc);
        end
    endtask

    // Call with the clock low; returns in the low phase after the commit.
    task automatic run_req(input logic [1:0] k, input logic tk, input int nc, input int nt);
        logic [1:0]  es;
        logic [31:0] opts [4];
        logic [31:0] tgt;
        logic        tr;
        int          fin;
        if (k == 2'd0) es = 2'd0;
        else if (k == 2'd1) es = tk ? 2'd1 : 2'd0;
        else if (k == 2'd2) es = 2'd2;
        else es = 2'd3;
        opts = '{m_pc + 32'd4, btgt, jtgt, vec};
        tgt = opts[es];
        tr = (tgt[1:0] != 2'b00) && (k != 2'd3);
        fin = tr ? nc + 2 + nt : nc + 1;

        req_valid = 1'b1;
        req_kind = k;
        branch_taken = tk;
        stall = 1'(($urandom_range(1)));
        #1;
        chk("ready_idle", {31'd0, req_ready}, 32'd1);
        chk("sel_idle", {30'd0, selector}, 32'd0);
        @(posedge clk);
        for (int c = 0; c <= fin; c++) begin
            @(negedge clk);
            req_valid = ($urandom_range(3) == 0);
            req_kind = 2'($urandom_range(3));
            branch_taken = 1'(($urandom_range(1)));
            if (c == 0) stall = 1'(($urandom_range(1)));
            else if (c <= nc) stall = 1'b1;
            else if (c == nc + 1) stall = 1'b0;
            else stall = (c < fin);
            #1;
            chk("sel", {30'd0, selector}, {30'd0, (tr && c > nc + 1) ? 2'd3 : es});
            chk("pc_write", {31'd0, pc_write}, {31'd0, c == fin});
            chk("done", {31'd0, done}, {31'd0, c == fin});
            chk("trap", {31'd0, trap}, {31'd0, c == fin && tr});
            chk("ready_busy", {31'd0, req_ready}, 32'd0);
            chk("pc_hold", pc, m_pc);
        end
        m_pc = tr ? vec : tgt;
        m_ret = m_ret + 32'd1;
        if (tr && m_trp != 16'hFFFF) m_trp = m_trp + 16'd1;
        @(negedge clk);
        req_valid = 1'b0;
        stall = 1'b0;
        #1;
        chk("pc", pc, m_pc);
        chk("done_end", {31'd0, done}, 32'd0);
        chk("ready_end", {31'd0, req_ready}, 32'd1);
        chk_cnt();
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0;
        req_kind = 2'd0;
        branch_taken = 1'b0;
        stall = 1'b0;
        btgt = 32'h0;
        jtgt = 32'h0;
        vec = 32'h8000_0180;
        m_pc = 32'h0;
        m_ret = 32'h0;
        m_trp = 16'h0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_sel", {30'd0, selector}, 32'd0);
        chk("rst_wr", {31'd0, pc_write}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_trap", {31'd0, trap}, 32'd0);
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk_cnt();
        reset = 1'b0;
        @(negedge clk);

        run_req(2'd0, 1'b0, 0, 0);
        btgt = 32'h0000_0040;
        run_req(2'd1, 1'b1, 0, 0);
        btgt = 32'h0000_0080;
        run_req(2'd1, 1'b0, 0, 0);
        jtgt = 32'h0000_0102;
        run_req(2'd2, 1'b0, 0, 0);
        jtgt = 32'h0000_0300;
        run_req(2'd2, 1'b0, 4, 0);
        jtgt = 32'h0000_0206;
        run_req(2'd2, 1'b0, 1, 3);
        vec = 32'h8000_0182;
        run_req(2'd3, 1'b0, 0, 0);
        vec = 32'h8000_0100;
        run_req(2'd0, 1'b0, 0, 1);
        idle(2);

        jtgt = 32'h0000_0200;
        req_valid = 1'b1;
        req_kind = 2'd2;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        stall = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_wr", {31'd0, pc_write}, 32'd0);
        chk("abort_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        #1;
        m_pc = 32'h0;
        m_ret = 32'h0;
        m_trp = 16'h0;
        chk("abort_pc", pc, 32'h0);
        chk("abort_sel", {30'd0, selector}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk_cnt();
        reset = 1'b0;
        stall = 1'b0;
        idle(1);

        for (int i = 0; i < 150; i++) begin
            btgt = $urandom & 32'hFFFF_FFFC;
            jtgt = $urandom & 32'hFFFF_FFFC;
            vec = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(3) == 0) btgt[1:0] = 2'($urandom_range(3));
            if ($urandom_range(3) == 0) jtgt[1:0] = 2'($urandom_range(3));
            if ($urandom_range(7) == 0) vec[1:0] = 2'($urandom_range(3));
            run_req(2'($urandom_range(3)), 1'(($urandom_range(1))),
                    int'($urandom_range(3)), int'($urandom_range(2)));
            idle(int'($urandom_range(2)));
        end

`ifdef PC_RETIRE_CNT_EN
        @(negedge clk);
        force dut.r_retire_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.r_retire_cnt;
        m_ret = 32'hFFFF_FFFF;
        vec = 32'h0000_1000;
        run_req(2'd3, 1'b0, 0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
